// File: rtl/icache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the
// direct-mapped, read-only instruction cache.
package icache_pkg;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int LINE_WORDS = 8;
  localparam int NUM_SETS   = 64;

  localparam int BYTE_W   = 3;
  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int LINE_LSB = BYTE_W + OFF_W;
  localparam int TAG_W    = ADDR_W - IDX_W - LINE_LSB;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    REFILL,
    RESP
  } icache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[LINE_LSB +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[BYTE_W +: OFF_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetcher-side request/response pair plus the line-refill memory read port.
interface icache_responder_if;
  import icache_pkg::*;

  // Fetch side: request is a level held with a stable address until a one-cycle
  // result_ready pulse. Memory side: a request transfers on a cycle where
  // mem_req_valid && mem_req_ready; once raised, valid and addr hold until then.
  // Each cycle with mem_resp_valid carries one refill beat, no backpressure.
  logic              request;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              result_ready;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  request, address, mem_req_ready, mem_resp_valid, mem_resp_data,
    output instruction, result_ready, mem_req_valid, mem_req_addr
  );

  modport master (
    output request, address, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instruction, result_ready, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for the cache: combinational read, whole-line
// invalidate, and one-word-per-cycle refill write that validates on the last beat.
module icache_array
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [OFF_W-1:0]  i_rd_off,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_inv_en,
  input  logic [IDX_W-1:0]  i_inv_idx,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [OFF_W-1:0]  i_wr_off,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  input  logic [TAG_W-1:0]  i_wr_tag
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [DATA_W-1:0]   r_data [NUM_SETS][LINE_WORDS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

  // A line only becomes valid once its final beat lands, so an interrupted
  // refill never exposes a partial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en) begin
        r_valid[i_inv_idx] <= 1'b0;
      end
      if (i_wr_en && i_wr_last) begin
        r_valid[i_wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
      if (i_wr_last) begin
        r_tag[i_wr_idx] <= i_wr_tag;
      end
    end
  end

endmodule

// File: rtl/icache_responder.sv
// Instruction-cache responder: latches a fetch request, looks it up, refills the
// whole line from memory on a miss, then replays the lookup and pulses result_ready.
module icache_responder
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  icache_responder_if.slave   bus,
  output icache_state_e       o_state
);

  icache_state_e     r_state;
  logic [ADDR_W-1:0] r_req_addr;
  logic [OFF_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_instruction;
  logic              r_result_ready;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_req_addr;

  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [DATA_W-1:0] w_rd_data;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_inv_en;
  logic              w_wr_en;
  logic              w_last_beat;

  assign w_idx       = addr_idx(r_req_addr);
  assign w_tag       = addr_tag(r_req_addr);
  assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
  assign w_inv_en    = (r_state == MEM_REQ) && bus.mem_req_ready;
  assign w_wr_en     = (r_state == REFILL) && bus.mem_resp_valid;
  assign w_last_beat = (r_cnt == OFF_W'(LINE_WORDS - 1));

  icache_array u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_idx),
    .i_rd_off   (addr_off(r_req_addr)),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_inv_en   (w_inv_en),
    .i_inv_idx  (w_idx),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_idx),
    .i_wr_off   (r_cnt),
    .i_wr_data  (bus.mem_resp_data),
    .i_wr_last  (w_last_beat),
    .i_wr_tag   (w_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_req_addr      <= '0;
      r_cnt           <= '0;
      r_instruction   <= '0;
      r_result_ready  <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
    end else begin
      r_result_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.request) begin
            r_req_addr <= bus.address;
            r_state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_instruction  <= w_rd_data;
            r_result_ready <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_mem_req_addr  <= line_base(r_req_addr);
            r_mem_req_valid <= 1'b1;
            r_state         <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_resp_valid) begin
            r_cnt <= r_cnt + 1'b1;
            // Back to LOOKUP rather than answering directly: the replay hits.
            if (w_last_beat) begin
              r_state <= LOOKUP;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instruction   = r_instruction;
  assign bus.result_ready  = r_result_ready;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_addr  = r_mem_req_addr;
  assign o_state           = r_state;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios then randomized
// fetches, checked against a line-presence model and a deterministic memory image.
module tb_icache_responder;
  import icache_pkg::*;

  logic clk;
  logic reset;
  icache_state_e dbg_state;

  icache_responder_if bus();

  icache_responder dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int hs_count = 0;
  logic [63:0] last_hs_addr = '0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_mem_q[$];

  // line-presence model: per set, which line (address >> 12) is resident
  bit          model_valid [64];
  logic [51:0] model_tag   [64];

  // memory responder configuration
  int cfg_req_wait    = 0;   // <0: random 0..3
  int cfg_rand_gaps   = 0;
  int cfg_gap_at      = -1;
  int cfg_gap         = 0;
  int cfg_abort_after = -1;
  int cfg_noise       = 0;
  bit abort_done      = 0;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] line;
    logic [63:0] w;
    line = a >> 6;
    w    = (a >> 3) & 64'd7;
    if (line == 64'h40) return 64'hA0 + w;
    if (line == 64'h80) return 64'hB0 + w;
    return {a[63:3], 3'b000} ^ 64'hC3C3_0000_5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    summary_and_finish();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int w;
    int g;
    logic [63:0] base;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_req_valid || reset) begin
        bus.mem_resp_valid = (cfg_noise != 0) && ($urandom_range(0, 3) == 0);
        bus.mem_resp_data  = {$urandom, $urandom};
        continue;
      end
      bus.mem_resp_valid = 1'b0;
      base = bus.mem_req_addr;
      w = (cfg_req_wait < 0) ? int'($urandom_range(0, 3)) : cfg_req_wait;
      repeat (w) begin
        @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
        g = (cfg_rand_gaps != 0) ? int'($urandom_range(0, 2)) : 0;
        if (k == cfg_gap_at) g += cfg_gap;
        repeat (g) begin
          @(posedge clk); #1;
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_word(base + 64'(k * 8));
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        if (k == cfg_abort_after) begin
          abort_done = 1'b1;
          break;
        end
      end
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  initial begin
    logic        prev_mv;
    logic        prev_mr;
    logic [63:0] prev_ma;
    logic        prev_rr;
    logic [63:0] hold;
    prev_mv = 0; prev_mr = 0; prev_ma = '0; prev_rr = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = '0; prev_mv = 0; prev_mr = 0; prev_rr = 0;
        continue;
      end
      if (bus.result_ready) begin
        n_chk++;
        if (prev_rr) begin
          n_fail++;
          $display("FAIL result_ready_pulse: got high 2 cycles running, expected 1-cycle pulse at %0t", $time);
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got result_ready with instruction %h, expected none at %0t",
                   bus.instruction, $time);
        end else begin
          hold = exp_q.pop_front();
          check("instruction", bus.instruction, hold);
        end
      end else begin
        check("instruction_hold", bus.instruction, hold);
      end
      if (prev_mv && !prev_mr) begin
        check("mem_req_valid_held", 64'(bus.mem_req_valid), 64'd1);
        check("mem_req_addr_stable", bus.mem_req_addr, prev_ma);
      end
      if (bus.mem_req_valid) begin
        check("mem_req_addr_aligned", bus.mem_req_addr & 64'd63, 64'd0);
        if (bus.mem_req_ready) begin
          hs_count++;
          last_hs_addr = bus.mem_req_addr;
          if (exp_mem_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_mem_req: got handshake at %h, expected none at %0t",
                     bus.mem_req_addr, $time);
          end else begin
            check("mem_req_addr", bus.mem_req_addr, exp_mem_q.pop_front());
          end
        end
      end
      prev_mv = bus.mem_req_valid;
      prev_mr = bus.mem_req_ready;
      prev_ma = bus.mem_req_addr;
      prev_rr = bus.result_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    reset       = 1'b1;
    bus.request = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_outputs();
    check("reset_result_ready",  64'(bus.result_ready),  64'd0);
    check("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("reset_instruction",   bus.instruction,        64'd0);
    check("reset_mem_req_addr",  bus.mem_req_addr,       64'd0);
  endtask

  // One fetch. A request already held from the previous fetch makes this a
  // back-to-back fetch: the new address waits out the RESP cycle, so a hit
  // takes 3 cycles instead of 2.
  task automatic fetch(input logic [63:0] a, input bit keep_req);
    int          idx;
    logic [51:0] tag;
    bit          hit;
    bit          b2b;
    int          hs_before;
    int          cyc;
    idx = int'((a >> 6) & 64'd63);
    tag = 52'(a >> 12);
    hit = model_valid[idx] && (model_tag[idx] == tag);
    exp_q.push_back(mem_word(a & ~64'd7));
    if (!hit) exp_mem_q.push_back(a & ~64'd63);
    model_valid[idx] = 1'b1;
    model_tag[idx]   = tag;
    b2b       = bus.request;
    hs_before = hs_count;
    bus.request = 1'b1;
    bus.address = a;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 300) timeout_fail("fetch_result_ready");
    end while (!bus.result_ready);
    check("refill_count", 64'(hs_count - hs_before), hit ? 64'd0 : 64'd1);
    if (hit) check("hit_latency", 64'(cyc), b2b ? 64'd3 : 64'd2);
    if (!keep_req) begin
      bus.request = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic fetch_reset_mid_refill(input logic [63:0] a);
    int cyc;
    cfg_abort_after = 4;
    abort_done      = 1'b0;
    exp_mem_q.push_back(a & ~64'd63);
    bus.request = 1'b1;
    bus.address = a;
    cyc = 0;
    while (!abort_done) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 300) timeout_fail("abort_refill");
    end
    do_reset(2);
    cfg_abort_after = -1;
    check_reset_outputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] a;
    logic [51:0] tags [4];
    tags[0] = 52'd1; tags[1] = 52'd2; tags[2] = 52'd3; tags[3] = 52'd5;
    bus.request = 1'b0;
    bus.address = '0;
    do_reset(3);
    check_reset_outputs();

    // cold miss, then hit in the same line
    fetch(64'h1000, 0);
    check("cold_miss_req_addr", last_hs_addr, 64'h1000);
    check("cold_miss_instr", bus.instruction, 64'hA0);
    fetch(64'h1018, 0);
    check("hit_instr", bus.instruction, 64'hA3);

    // conflict eviction in set 0
    fetch(64'h2000, 0);
    check("evict_instr", bus.instruction, 64'hB0);
    fetch(64'h1008, 0);
    check("evict_back_req_addr", last_hs_addr, 64'h1000);
    check("evict_back_instr", bus.instruction, 64'hA1);

    // request backpressure plus a stall between beats 3 and 4
    cfg_req_wait = 5; cfg_gap_at = 4; cfg_gap = 2;
    fetch(64'h2010, 0);
    check("backpressure_instr", bus.instruction, 64'hB2);
    cfg_req_wait = 0; cfg_gap_at = -1; cfg_gap = 0;

    // reset after beat 4 of a refill; the line must come back as a miss
    fetch_reset_mid_refill(64'h3000);
    fetch(64'h3000, 0);
    check("after_abort_req_addr", last_hs_addr, 64'h3000);

    // back-to-back with request held across both fetches
    fetch(64'h1000, 1);
    fetch(64'h1008, 0);
    check("b2b_instr", bus.instruction, 64'hA1);

    // randomized traffic over a few sets and conflicting tags
    cfg_req_wait = -1; cfg_rand_gaps = 1; cfg_noise = 1;
    for (int n = 0; n < 200; n++) begin
      a = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      fetch(a, $urandom_range(0, 3) == 0);
      if (!bus.request) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    bus.request = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    summary_and_finish();
  end

  initial begin
    #2ms;
    timeout_fail("global_watchdog");
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder end of the fetcher-to-instruction-cache request protocol: accepts `request`/`address` from the instruction fetcher and returns a 64-bit `instruction` with a `result_ready` pulse.
- Direct-mapped, read-only instruction cache. Hits are served from local arrays; misses refill one full line from a simple memory read port, then replay the lookup.
- Sits between the fetch stage and the memory/bus adapter.

Parameters:
- ADDR_W, 64, fetch address width in bits.
- DATA_W, 64, instruction word width (one fetch beat, 8 bytes).
- LINE_WORDS, 8, DATA_W words per line (power of 2, >=2).
- NUM_SETS, 64, number of lines (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- request  in  1  fetcher request; level, held by the fetcher until it sees result_ready.
- address  in  ADDR_W  fetch address; must be stable while request=1; bits [2:0] ignored.
- instruction  out  DATA_W  fetched word; valid when result_ready=1, then holds its value until the next result.
- result_ready  out  1  one-cycle pulse: instruction valid.
- mem_req_valid  out  1  line-refill read request.
- mem_req_ready  in  1  memory accepts the request (handshake on valid&&ready).
- mem_req_addr  out  ADDR_W  line-aligned refill address (low log2(LINE_WORDS*8) bits zero).
- mem_resp_valid  in  1  one refill beat present.
- mem_resp_data  in  DATA_W  refill beat; beats arrive in ascending word order starting at word 0.

Behaviour:
- Address split:
  - [2:0] byte offset, ignored.
  - next OFF_W = log2(LINE_WORDS) bits: word offset.
  - next IDX_W = log2(NUM_SETS) bits: index.
  - remaining upper bits: tag.
- Storage: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][LINE_WORDS]; all flop/register arrays with combinational read.
- Reset: state=IDLE, all valid bits=0, result_ready=0, mem_req_valid=0, instruction=0, mem_req_addr=0, beat counter=0.
- IDLE:
  - request=1 → latch address into req_addr_q; go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP:
  - hit = valid[idx] && tag[idx]==tag(req_addr_q).
  - Hit: instruction <= data[idx][off]; result_ready <= 1; go to RESP.
  - Miss: mem_req_addr <= line-aligned req_addr_q; mem_req_valid <= 1; go to MEM_REQ.
- MEM_REQ:
  - Hold mem_req_valid=1 and mem_req_addr stable until mem_req_ready=1.
  - On handshake: mem_req_valid <= 0; clear valid[idx]; beat counter=0; go to REFILL.
- REFILL:
  - Each cycle with mem_resp_valid=1: data[idx][cnt] <= mem_resp_data; cnt++.
  - On beat LINE_WORDS-1: tag[idx] <= tag; valid[idx] <= 1; go to LOOKUP, which then hits.
  - Cycles with mem_resp_valid=0 are stalls; no timeout.
- RESP:
  - result_ready=1 for exactly this cycle; go to IDLE.
  - A request seen in the RESP cycle is ignored. Earliest acceptance of the next request is the IDLE cycle that follows.
- Latency, counted from the request-sampling edge:
  - Hit: result_ready high 2 cycles later.
  - Miss: 2 + request-wait + beat cycles + 1 replay lookup.
- A new refill of the same index overwrites the line (direct-mapped replacement).
- Reset mid-refill: return to IDLE, all valid bits cleared, partial line discarded. Memory side is reset by the same signal, so no stale beats arrive.
- request dropping mid-operation: the current operation completes and result_ready still pulses. The fetcher is not permitted to do this.
- mem_resp_valid outside REFILL: ignored.

Decomposition:
- Shared package icache_pkg holds:
  - state enum `icache_state_e` {IDLE, LOOKUP, MEM_REQ, REFILL, RESP}.
  - localparams OFF_W, IDX_W, TAG_W.
  - helper functions addr_tag/addr_idx/addr_off/line_base.
- One sub-module: icache_array. It holds valid/tag/data storage, provides a combinational read port, a line-invalidate port and a per-beat write port, and clears valid bits on reset.
- The top level holds the FSM, request latch, beat counter and memory handshake.

Test Plan:
- Cold miss. After reset, request at address 0x1000 (idx 0, tag 1). Memory ready immediately, beats 0xA0..0xA7.
  - Required: mem_req_addr=0x1000, one request handshake.
  - Required: instruction=0xA0 with a single result_ready pulse.
- Hit. Then request at address 0x1018.
  - Required: result_ready exactly 2 cycles after sampling, instruction=0xA3, no mem_req_valid.
- Conflict eviction.
  - Request 0x2000 (idx 0, tag 2) → refill beats 0xB0..0xB7, instruction=0xB0.
  - Then request 0x1008 → miss again, mem_req_addr=0x1000.
- Backpressure. Hold mem_req_ready=0 for 5 cycles on a miss, then insert 2 idle cycles between beats 3 and 4.
  - Required: mem_req_valid and mem_req_addr stable throughout; correct data returned; exactly one handshake.
- Reset mid-refill. Assert reset after beat 4 of a refill at 0x3000, then request 0x3000 again.
  - Required: full miss with a new mem_req; the line was not left valid.
- Back-to-back. Request held continuously across two fetches (0x1000 then 0x1008).
  - Required: second request sampled in the IDLE cycle after RESP, never in RESP.
